fadd_exception_pipe: RTL and testbench
======================================

FADD_EXCEPTION_PIPE -- requirements
Module: fadd_exception_pipe

Interface
REQ-001 Parameter NE, default 11: exponent width.
REQ-002 Parameter NF, default 52: fraction width; operand width W = 1+NE+NF.
REQ-003 Parameter CNTW, default 8: width of saturating invalid-event counter.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand set offered.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 A, B  input  W each  operands: sign MSB, then exponent, then fraction.
REQ-009 op  input  3  000 add, 001 sub, 11x/01x/10x convert.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  downstream consumes result.
REQ-012 Ztype  output  4  result class code.
REQ-013 Invalid, Denorm, ANorm, BNorm, Sub  output  1 each  per-operation flags.
REQ-014 flag_clr  input  1  clears sticky flags and counter.
REQ-015 sticky_nv, sticky_dn  output  1 each  accumulated Invalid / Denorm.
REQ-016 nv_count  output  CNTW  saturating count of accepted Invalid results.

Function
REQ-017 Per operand: zero = exp 0 & frac 0; denorm = exp 0 & frac≠0; inf = exp all-ones & frac 0; NaN = exp all-ones & frac≠0; SNaN = NaN & frac MSB 0; Norm = exp≠0.
REQ-018 addsub = op[2:1]==00; convert = ~addsub; Sub = addsub & (sA^sB^op[0]).
REQ-019 Invalid = (SNaN(A) | SNaN(B) | addsub&inf(A)&inf(B)&(sA^sB^op[0])) & ~convert.
REQ-020 Denorm = denorm(A)&(op[2]|~op[1]) | denorm(B)&addsub.
REQ-021 QNaN result = Invalid | NaN(A) | NaN(B)&addsub; Inf results suppressed when QNaN.
REQ-022 +Inf = inf(A)&~sA | addsub&inf(B)&~(sB^op[0]); -Inf = inf(A)&sA | addsub&inf(B)&(sB^op[0]); signs agree when both inf (else Invalid).
REQ-023 Ztype: 0001 QNaN, 0010 -Inf, 0011 +Inf, 0100 both zero → +0, 0101 both zero opposite effective signs, 0110 both zero → -0, 1000 op=110, 0000 otherwise; priority 1000 > NaN > Inf > zero; NaN/Inf codes masked for op=01x.
REQ-024 Two-stage pipeline: S1 registers classification bits, signs, op; S2 registers all outputs; latency 2 cycles from accept to out_valid with out_ready held high.
REQ-025 Accept on in_valid & in_ready; output transfer on out_valid & out_ready.
REQ-026 S2 loads when S2 empty or transferring; S1 loads when S1 empty or advancing to S2; in_ready = ~S1full | S1advance; throughput one op per cycle, no bubbles.
REQ-027 out_ready low: outputs and out_valid held stable; ≤2 ops buffered, then in_ready low.
REQ-028 Sticky/counter update only on output transfer: sticky_nv |= Invalid, sticky_dn |= Denorm, nv_count += Invalid, saturating at 2^CNTW-1.
REQ-029 flag_clr with transfer same cycle: clear first, then apply that transfer's flags.

Reset
REQ-030 reset clears S1/S2 valid bits, out_valid=0, Ztype=0, all flags 0, sticky 0, nv_count 0; in_ready=1 in first cycle after deassert.
REQ-031 reset mid-operation discards in-flight ops; no partial flag update.

Structure
REQ-032 Ztype codes, op encodings and default NE/NF in shared fpu package.
REQ-033 One sub-module fp_classify (per-operand zero/denorm/inf/nan/snan/norm), instantiated twice.

Verification
REQ-034 A=0x7FF0000000000000, B=0x7FF0000000000000, op=001 → Invalid=1, Ztype=0001, Sub=1, nv_count=1 after transfer.
REQ-035 A=0x0000000000000000, B=0x8000000000000000, op=000 → Ztype=0101, Invalid=0, out_valid exactly 2 cycles after accept.
REQ-036 A=0x0000000000000001, B=0x3FF0000000000000, op=000 → Denorm=1, ANorm=0, BNorm=1, sticky_dn=1.
REQ-037 Stream 4 ops, out_ready low 3 cycles → in_ready low after 2 accepts, no loss/duplication, order preserved.
REQ-038 CNTW=2, 5 Invalid ops → nv_count=3; flag_clr with Invalid transfer same cycle → sticky_nv=1, nv_count=1.
REQ-039 Reset asserted with both stages full → out_valid=0 next edge, flags 0.

Source files
------------

// File: rtl/fadd_exception_pipe_pkg.sv
// Shared definitions for the FP add/sub exception pipeline: default formats,
// op encodings, result class codes and the per-operand class record.
package fadd_exception_pipe_pkg;

    localparam int FPU_NE = 11;
    localparam int FPU_NF = 52;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_CVT_Z = 3'b110;

    localparam logic [3:0] ZT_NONE  = 4'b0000;
    localparam logic [3:0] ZT_QNAN  = 4'b0001;
    localparam logic [3:0] ZT_NINF  = 4'b0010;
    localparam logic [3:0] ZT_PINF  = 4'b0011;
    localparam logic [3:0] ZT_PZERO = 4'b0100;
    localparam logic [3:0] ZT_XZERO = 4'b0101;
    localparam logic [3:0] ZT_NZERO = 4'b0110;
    localparam logic [3:0] ZT_CVT   = 4'b1000;

    typedef struct packed {
        logic zero;
        logic denorm;
        logic inf;
        logic nan;
        logic snan;
        logic norm;
    } fp_class_t;

    typedef struct packed {
        logic [3:0] ztype;
        logic       invalid;
        logic       denorm;
        logic       a_norm;
        logic       b_norm;
        logic       sub;
    } fp_result_t;

endpackage

// File: rtl/fp_classify.sv
// Purely combinational class decode of one IEEE-style operand.
module fp_classify
    import fadd_exception_pipe_pkg::*;
#(
    parameter int NE = FPU_NE,
    parameter int NF = FPU_NF
) (
    input  logic [NE+NF:0] operand,
    output fp_class_t      cls
);

    logic [NE-1:0] exp_f;
    logic [NF-1:0] frac_f;
    logic          exp_zero;
    logic          exp_ones;
    logic          frac_zero;

    assign exp_f     = operand[NE+NF-1:NF];
    assign frac_f    = operand[NF-1:0];
    assign exp_zero  = (exp_f == '0);
    assign exp_ones  = &exp_f;
    assign frac_zero = (frac_f == '0);

    always_comb begin
        cls        = '0;
        cls.zero   = exp_zero & frac_zero;
        cls.denorm = exp_zero & ~frac_zero;
        cls.inf    = exp_ones & frac_zero;
        cls.nan    = exp_ones & ~frac_zero;
        // Quiet bit is the fraction MSB; a clear quiet bit marks a signalling NaN.
        cls.snan   = exp_ones & ~frac_zero & ~frac_f[NF-1];
        cls.norm   = ~exp_zero;
    end

endmodule

// File: rtl/fadd_exception_pipe.sv
// Two-stage valid/ready pipeline producing the exception flags and result
// class of an FP add/sub/convert, plus sticky flags and a saturating NV count.
module fadd_exception_pipe
    import fadd_exception_pipe_pkg::*;
#(
    parameter int NE   = FPU_NE,
    parameter int NF   = FPU_NF,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NE+NF:0]  A,
    input  logic [NE+NF:0]  B,
    input  logic [2:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      Ztype,
    output logic            Invalid,
    output logic            Denorm,
    output logic            ANorm,
    output logic            BNorm,
    output logic            Sub,
    input  logic            flag_clr,
    output logic            sticky_nv,
    output logic            sticky_dn,
    output logic [CNTW-1:0] nv_count
);

    fp_class_t ca_in;
    fp_class_t cb_in;

    fp_classify #(.NE(NE), .NF(NF)) u_class_a (.operand(A), .cls(ca_in));
    fp_classify #(.NE(NE), .NF(NF)) u_class_b (.operand(B), .cls(cb_in));

    logic       s1_valid_q, s1_valid_d;
    fp_class_t  s1_ca_q, s1_ca_d;
    fp_class_t  s1_cb_q, s1_cb_d;
    logic       s1_sa_q, s1_sa_d;
    logic       s1_sb_q, s1_sb_d;
    logic [2:0] s1_op_q, s1_op_d;

    logic       s2_valid_q, s2_valid_d;
    fp_result_t s2_res_q, s2_res_d;

    logic            sticky_nv_q, sticky_nv_d;
    logic            sticky_dn_q, sticky_dn_d;
    logic [CNTW-1:0] nv_count_q, nv_count_d;

    logic s2_load, s1_adv, accept, xfer;
    fp_result_t res;

    always_comb begin
        s2_load  = ~s2_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_load;
        in_ready = ~s1_valid_q | s1_adv;
        accept   = in_valid & in_ready;
        xfer     = s2_valid_q & out_ready;
    end

    // Exception evaluation from the stage-1 classification.
    logic addsub, eff_sb, qnan, pinf, ninf, spec_mask, both_zero;

    always_comb begin
        addsub    = (s1_op_q[2:1] == 2'b00);
        eff_sb    = s1_sb_q ^ s1_op_q[0];
        res       = '0;
        res.sub   = addsub & (s1_sa_q ^ eff_sb);
        res.invalid = (s1_ca_q.snan | s1_cb_q.snan |
                       (s1_ca_q.inf & s1_cb_q.inf & (s1_sa_q ^ eff_sb))) & addsub;
        res.denorm  = (s1_ca_q.denorm & (s1_op_q[2] | ~s1_op_q[1])) |
                      (s1_cb_q.denorm & addsub);
        res.a_norm  = s1_ca_q.norm;
        res.b_norm  = s1_cb_q.norm;
        qnan      = res.invalid | s1_ca_q.nan | (s1_cb_q.nan & addsub);
        pinf      = ~qnan & ((s1_ca_q.inf & ~s1_sa_q) | (addsub & s1_cb_q.inf & ~eff_sb));
        ninf      = ~qnan & ((s1_ca_q.inf & s1_sa_q) | (addsub & s1_cb_q.inf & eff_sb));
        spec_mask = (s1_op_q[2:1] == 2'b01);
        both_zero = addsub & s1_ca_q.zero & s1_cb_q.zero;
        if (s1_op_q == OP_CVT_Z)
            res.ztype = ZT_CVT;
        else if (qnan & ~spec_mask)
            res.ztype = ZT_QNAN;
        else if (ninf & ~spec_mask)
            res.ztype = ZT_NINF;
        else if (pinf & ~spec_mask)
            res.ztype = ZT_PINF;
        else if (both_zero)
            res.ztype = (s1_sa_q != eff_sb) ? ZT_XZERO : (s1_sa_q ? ZT_NZERO : ZT_PZERO);
        else
            res.ztype = ZT_NONE;
    end

    always_comb begin
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s1_ca_d    = accept ? ca_in : s1_ca_q;
        s1_cb_d    = accept ? cb_in : s1_cb_q;
        s1_sa_d    = accept ? A[NE+NF] : s1_sa_q;
        s1_sb_d    = accept ? B[NE+NF] : s1_sb_q;
        s1_op_d    = accept ? op : s1_op_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_res_d   = s1_adv ? res : s2_res_q;
    end

    // Clear is applied before the transferring result's flags are folded in.
    always_comb begin
        sticky_nv_d = flag_clr ? 1'b0 : sticky_nv_q;
        sticky_dn_d = flag_clr ? 1'b0 : sticky_dn_q;
        nv_count_d  = flag_clr ? '0 : nv_count_q;
        if (xfer) begin
            sticky_nv_d = sticky_nv_d | s2_res_q.invalid;
            sticky_dn_d = sticky_dn_d | s2_res_q.denorm;
            if (s2_res_q.invalid && (nv_count_d != {CNTW{1'b1}}))
                nv_count_d = nv_count_d + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_ca_q     <= '0;
            s1_cb_q     <= '0;
            s1_sa_q     <= 1'b0;
            s1_sb_q     <= 1'b0;
            s1_op_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            sticky_nv_q <= 1'b0;
            sticky_dn_q <= 1'b0;
            nv_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ca_q     <= s1_ca_d;
            s1_cb_q     <= s1_cb_d;
            s1_sa_q     <= s1_sa_d;
            s1_sb_q     <= s1_sb_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            sticky_nv_q <= sticky_nv_d;
            sticky_dn_q <= sticky_dn_d;
            nv_count_q  <= nv_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign Ztype     = s2_res_q.ztype;
    assign Invalid   = s2_res_q.invalid;
    assign Denorm    = s2_res_q.denorm;
    assign ANorm     = s2_res_q.a_norm;
    assign BNorm     = s2_res_q.b_norm;
    assign Sub       = s2_res_q.sub;
    assign sticky_nv = sticky_nv_q;
    assign sticky_dn = sticky_dn_q;
    assign nv_count  = nv_count_q;

endmodule

// File: tb/tb_fadd_exception_pipe.sv
// Directed bench for fadd_exception_pipe (double format, 2-bit NV counter).
module tb_fadd_exception_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A, B;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  Ztype;
    logic        Invalid, Denorm, ANorm, BNorm, Sub;
    logic        flag_clr;
    logic        sticky_nv, sticky_dn;
    logic [1:0]  nv_count;

    int n_checks = 0;
    int n_errors = 0;

    fadd_exception_pipe #(.NE(11), .NF(52), .CNTW(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Ztype(Ztype), .Invalid(Invalid), .Denorm(Denorm), .ANorm(ANorm),
        .BNorm(BNorm), .Sub(Sub), .flag_clr(flag_clr), .sticky_nv(sticky_nv),
        .sticky_dn(sticky_dn), .nv_count(nv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] PINF  = 64'h7FF0000000000000;
    localparam logic [63:0] NINF  = 64'hFFF0000000000000;
    localparam logic [63:0] PZERO = 64'h0000000000000000;
    localparam logic [63:0] NZERO = 64'h8000000000000000;
    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] DEN1  = 64'h0000000000000001;
    localparam logic [63:0] SNAN  = 64'h7FF0000000000001;
    localparam logic [63:0] QNAN  = 64'h7FF8000000000000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single op with out_ready high; entered and left at #1 after an edge, pipe empty.
    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] o, input logic [3:0] ez, input logic [4:0] ef);
        A = a; B = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, ".rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".lat1"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, ".lat2"}, out_valid, 1);
        check({tag, ".z"}, Ztype, ez);
        check({tag, ".flags"}, {Invalid, Denorm, ANorm, BNorm, Sub}, ef);
        $display("op %s A=%h B=%h op=%b Ztype=%b inv/dn/an/bn/sub=%b", tag, a, b, o, Ztype,
                 {Invalid, Denorm, ANorm, BNorm, Sub});
        @(posedge clk); #1;
        check({tag, ".drain"}, out_valid, 0);
    endtask

    logic [63:0] sa_v[4];
    logic [63:0] sb_v[4];
    logic [3:0]  ez_v[4];
    logic [3:0]  got[$];
    int          idx;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        A = '0; B = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ov", out_valid, 0);
        check("rst.z", Ztype, 0);
        check("rst.flags", {Invalid, Denorm, ANorm, BNorm, Sub}, 0);
        check("rst.sticky", {sticky_nv, sticky_dn, nv_count}, 0);
        reset = 1'b0;
        #1;
        check("rst.rdy", in_ready, 1);
        @(posedge clk); #1;

        run_one("inf_sub_inf", PINF, PINF, 3'b001, 4'b0001, 5'b10111);
        check("inf_sub_inf.cnt", nv_count, 1);
        check("inf_sub_inf.snv", sticky_nv, 1);
        run_one("pz_add_nz", PZERO, NZERO, 3'b000, 4'b0101, 5'b00001);
        run_one("den_add_one", DEN1, ONE, 3'b000, 4'b0000, 5'b01010);
        check("den_add_one.sdn", sticky_dn, 1);
        run_one("cvt110_nan", QNAN, PZERO, 3'b110, 4'b1000, 5'b00100);
        run_one("cvt010_ninf", NINF, PZERO, 3'b010, 4'b0000, 5'b00100);
        run_one("ninf_add_ninf", NINF, NINF, 3'b000, 4'b0010, 5'b00110);
        run_one("pinf_sub_ninf", PINF, NINF, 3'b001, 4'b0011, 5'b00110);
        run_one("snan_add", SNAN, ONE, 3'b000, 4'b0001, 5'b10110);
        run_one("nz_add_nz", NZERO, NZERO, 3'b000, 4'b0110, 5'b00000);
        run_one("pz_sub_nz", PZERO, NZERO, 3'b001, 4'b0100, 5'b00000);
        run_one("cvt101_den", DEN1, DEN1, 3'b101, 4'b0000, 5'b01000);
        run_one("cvt100_snan", SNAN, PZERO, 3'b100, 4'b0001, 5'b00100);
        check("seq.cnt", nv_count, 2);
        check("seq.sticky", {sticky_nv, sticky_dn}, 2'b11);

        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        check("clr.all", {sticky_nv, sticky_dn, nv_count}, 0);

        A = PINF; B = PINF; op = 3'b001; in_valid = 1'b1; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("sat.cnt", nv_count, 3);
        check("sat.snv", sticky_nv, 1);

        // Clear coincides with an Invalid transfer: that transfer survives the clear.
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clrx.ov", out_valid, 1);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        check("clrx.cnt", nv_count, 1);
        check("clrx.sticky", {sticky_nv, sticky_dn}, 2'b10);

        sa_v = '{PZERO, NZERO, PZERO, NINF};
        sb_v = '{NZERO, NZERO, PZERO, NINF};
        ez_v = '{4'h5, 4'h6, 4'h4, 4'h2};
        idx = 0;
        op = 3'b000;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 3);
            in_valid = (idx < 4);
            if (idx < 4) begin
                A = sa_v[idx]; B = sb_v[idx];
            end
            #1;
            if (c == 2) begin
                check("bp.rdy_low", in_ready, 0);
                check("bp.accepts", idx, 2);
                check("bp.z", {out_valid, Ztype}, {1'b1, 4'h5});
            end
            if (c == 3) check("bp.hold", {out_valid, Ztype}, {1'b1, 4'h5});
            if (out_valid && out_ready) begin
                got.push_back(Ztype);
                $display("stream out #%0d Ztype=%b", got.size() - 1, Ztype);
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp.count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check($sformatf("bp.order%0d", i), got[i], ez_v[i]);

        out_ready = 1'b0;
        A = PINF; B = PINF; op = 3'b001; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("full.state", {out_valid, Invalid, in_ready}, 3'b110);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst.ov", out_valid, 0);
        check("mrst.z", Ztype, 0);
        check("mrst.flags", {Invalid, Denorm, ANorm, BNorm, Sub}, 0);
        check("mrst.sticky", {sticky_nv, sticky_dn, nv_count}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mrst.rdy", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("mrst.noghost", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
